sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of switch inputs conditioned.
REQ-002 The block SHALL have parameter TICK_DIV, default 100000, giving the clk cycles per sample tick (must be at least 2).
REQ-003 The block SHALL have parameter STABLE_CNT, default 4, giving the consecutive differing ticks required to commit a change (must be at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port sw_raw, input, WIDTH bits: raw, asynchronous, bouncing board switches.
REQ-007 The block SHALL have port sw, output, WIDTH bits: debounced switch levels, registered; this is the downstream LED stage's sw input.
REQ-008 The block SHALL have port sw_rise, output, WIDTH bits: one-clk pulse per bit when sw commits 0 to 1.
REQ-009 The block SHALL have port sw_fall, output, WIDTH bits: one-clk pulse per bit when sw commits 1 to 0.
REQ-010 The block SHALL have port any_on, output, 1 bit: equals the OR-reduction of sw in the same cycle.

Function
REQ-011 Each sw_raw bit SHALL pass through a two-flop synchronizer (sync) before any other use.
REQ-012 The prescaler SHALL count 0..TICK_DIV-1, pulse tick for exactly one clk when count==TICK_DIV-1, then wrap to 0.
REQ-013 Each bit SHALL run an independent FSM with states IDLE and COUNT and counter cnt; it SHALL evaluate only on tick cycles and hold state otherwise.
REQ-014 In IDLE on tick: if sync!=sw, the FSM SHALL go to COUNT with cnt=1; otherwise it SHALL stay in IDLE.
REQ-015 In COUNT on tick with sync==sw (bounce), the FSM SHALL return to IDLE with cnt=0; no output change, no pulse.
REQ-016 In COUNT on tick with sync!=sw and cnt<STABLE_CNT-1, the FSM SHALL increment cnt.
REQ-017 In COUNT on tick with sync!=sw and cnt==STABLE_CNT-1 (commit), the FSM SHALL set sw<=sync, return to IDLE and set cnt=0.
REQ-018 sw_rise or sw_fall for a bit SHALL be high in exactly the clk cycle after the commit tick (the cycle sw first shows the new value), and low otherwise.
REQ-019 Latency from a stable sw_raw edge to sw change SHALL be 2 clk (sync) plus STABLE_CNT ticks, with up to one tick period of phase uncertainty.
REQ-020 Any input pulse shorter than STABLE_CNT-1 tick periods SHALL never reach sw.
REQ-021 Bits changing in the same tick SHALL commit in the same cycle; pulse vectors may carry multiple bits set.
REQ-022 sw_rise and sw_fall SHALL never be high simultaneously on the same bit.
REQ-023 cnt width SHALL be clog2(STABLE_CNT) bits and the prescaler width clog2(TICK_DIV) bits; neither counter shall overflow.

Reset
REQ-024 While rst_n is low: sync flops, prescaler, all FSMs (IDLE), cnt, sw, sw_rise, sw_fall SHALL be 0, and any_on SHALL be 0, regardless of clk.
REQ-025 Assertion of reset mid-count SHALL discard pending changes; after release, counting SHALL restart from prescaler 0 and cnt 0.

Structure
REQ-026 Package sw_pkg SHALL hold the default WIDTH and the per-bit FSM state type (IDLE, COUNT).
REQ-027 The per-bit sync+FSM SHALL be sub-module sw_debounce_bit, instantiated WIDTH times by generate; the prescaler SHALL remain in the parent and be shared.
REQ-028 The implementation SHALL contain no latches, no derived clocks, and no clock gating.

Verification (TICK_DIV=4, STABLE_CNT=3)
REQ-029 Reset scenario: hold rst_n=0 with sw_raw=4'hF -> sw=0, sw_rise=sw_fall=0, any_on=0 throughout.
REQ-030 Clean press scenario: sw_raw 0000->0001 held -> sw=0001 within 2+12 clk (plus up to 4 clk phase); sw_rise=0001 for 1 clk; any_on=1.
REQ-031 Bounce scenario: bit1 high for 4 clk then low, repeated -> sw[1] stays 0; no sw_rise or sw_fall pulses.
REQ-032 Simultaneous scenario: sw_raw 0000->1100 -> sw=1100 in one cycle; sw_rise=1100 for exactly 1 clk.
REQ-033 Release scenario: from sw=0001, sw_raw->0000 held -> sw=0000; sw_fall=0001 for 1 clk; any_on=0.
REQ-034 Reset mid-count scenario: pulse rst_n low after 2 ticks of a pending change -> sw stays 0; after release, the commit takes a full 3 ticks again.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared defaults and the per-bit debounce state type for the switch conditioner.
package sw_pkg;

  localparam int SW_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchronizer followed by a tick-sampled stability counter.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic sw,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sw_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // synchronizer stage boundary: raw -> sync_p0 -> sync_p1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sw    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sw    <= sw_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Edge pulses are registered alongside sw so they appear in the first cycle of the new level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sw_nxt    = sw;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (sync_p1 != sw) begin
            state_nxt = COUNT;
            cnt_nxt   = CNT_W'(1);
          end
        end
        COUNT: begin
          if (sync_p1 == sw) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sw_nxt    = sync_p1;
            rise_nxt  = sync_p1;
            fall_nxt  = ~sync_p1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer: one shared sample-tick prescaler feeding WIDTH per-bit conditioners.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH      = SW_WIDTH_DEF,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_on
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .raw  (sw_raw[i]),
      .sw   (sw[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  assign any_on = |sw;

endmodule
